// File: rtl/memory_bridge.sv
// Bridges one controller-issued memory command onto a valid/ready system bus and
// holds the returned load word for the data path until the next successful read.
module memory_bridge #(
    parameter int unsigned TIMEOUT_CYCLES  = 255,
    parameter logic [31:0] RESET_READ_DATA = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        command_valid,
    input  logic        command_write,
    input  logic        misaligned,
    input  logic [31:0] read_address,
    input  logic [31:0] write_address,
    input  logic [31:0] write_data,
    input  logic [31:0] write_mask,
    output logic        busy,
    output logic        done,
    output logic        bus_error,
    output logic [31:0] read_data,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_write,
    output logic [31:0] bus_req_address,
    output logic [31:0] bus_req_data,
    output logic [3:0]  bus_req_strobe,
    input  logic        bus_resp_valid,
    input  logic [31:0] bus_resp_data,
    input  logic        bus_resp_error
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_e;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q;
    logic [7:0]  timer_q;
    logic        done_q;
    logic        bus_error_q;
    logic [31:0] read_data_q;
    logic        req_valid_q;
    logic        req_write_q;
    logic [31:0] req_address_q;
    logic [31:0] req_data_q;
    logic [3:0]  req_strobe_q;

    logic [31:0] cmd_address_d;
    logic [3:0]  cmd_strobe_d;
    logic        timeout_hit;

    // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cmd_address_d = (command_write ? write_address : read_address) & ~32'h3;
        cmd_strobe_d  = 4'b1111;
        if (command_write) begin
            for (int i = 0; i < 4; i++) begin
                cmd_strobe_d[i] = |write_mask[8*i +: 8];
            end
        end
    end

    // The current cycle is the last one allowed in REQ+WAIT; this wins over any handshake or response.
    assign timeout_hit = (timer_q == TIMEOUT_LAST);

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    // NOTE: the asynchronous reset clears every register (there is no memory array here), so the bus request drops the instant reset asserts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            timer_q       <= 8'd0;
            done_q        <= 1'b0;
            bus_error_q   <= 1'b0;
            read_data_q   <= RESET_READ_DATA;
            req_valid_q   <= 1'b0;
            req_write_q   <= 1'b0;
            req_address_q <= 32'd0;
            req_data_q    <= 32'd0;
            req_strobe_q  <= 4'd0;
        end else begin
            done_q      <= 1'b0;
            bus_error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Misaligned commands are refused outright; the controller traps instead.
                    if (command_valid && !misaligned) begin
                        req_write_q   <= command_write;
                        req_address_q <= cmd_address_d;
                        req_data_q    <= write_data;
                        req_strobe_q  <= cmd_strobe_d;
                        req_valid_q   <= 1'b1;
                        timer_q       <= 8'd0;
                        state_q       <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    timer_q <= timer_q + 8'd1;
                    if (timeout_hit) begin
                        req_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        bus_error_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else if (bus_req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    timer_q <= timer_q + 8'd1;
                    if (timeout_hit) begin
                        done_q      <= 1'b1;
                        bus_error_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else if (bus_resp_valid) begin
                        done_q      <= 1'b1;
                        bus_error_q <= bus_resp_error;
                        state_q     <= ST_DONE;
                        if (!req_write_q && !bus_resp_error) begin
                            read_data_q <= bus_resp_data;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy            = (state_q != ST_IDLE);
    assign done            = done_q;
    assign bus_error       = bus_error_q;
    assign read_data       = read_data_q;
    assign bus_req_valid   = req_valid_q;
    assign bus_req_write   = req_write_q;
    assign bus_req_address = req_address_q;
    assign bus_req_data    = req_data_q;
    assign bus_req_strobe  = req_strobe_q;

endmodule

// File: tb/tb_memory_bridge.sv
// Randomized self-checking bench for memory_bridge: a transaction-level model predicts
// completion time, error flag, request fields and the held load word for each command.
module tb_memory_bridge;

    localparam logic [31:0] RESET_WORD = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        sel;
    logic        command_valid;
    logic        command_write;
    logic        misaligned;
    logic [31:0] read_address;
    logic [31:0] write_address;
    logic [31:0] write_data;
    logic [31:0] write_mask;
    logic        bus_req_ready;
    logic        bus_resp_valid;
    logic [31:0] bus_resp_data;
    logic        bus_resp_error;

    logic        busy_a, done_a, err_a, valid_a, write_a;
    logic [31:0] rdata_a, addr_a, data_a;
    logic [3:0]  strobe_a;
    logic        busy_b, done_b, err_b, valid_b, write_b;
    logic [31:0] rdata_b, addr_b, data_b;
    logic [3:0]  strobe_b;

    logic        cmd_valid_a, cmd_valid_b;
    logic        o_busy, o_done, o_err, o_valid, o_write;
    logic [31:0] o_rdata, o_addr, o_data;
    logic [3:0]  o_strobe;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] rd_model [2];

    assign cmd_valid_a = command_valid & ~sel;
    assign cmd_valid_b = command_valid & sel;

    memory_bridge dut (
        .clk(clk), .reset(reset),
        .command_valid(cmd_valid_a), .command_write(command_write), .misaligned(misaligned),
        .read_address(read_address), .write_address(write_address),
        .write_data(write_data), .write_mask(write_mask),
        .busy(busy_a), .done(done_a), .bus_error(err_a), .read_data(rdata_a),
        .bus_req_valid(valid_a), .bus_req_ready(bus_req_ready), .bus_req_write(write_a),
        .bus_req_address(addr_a), .bus_req_data(data_a), .bus_req_strobe(strobe_a),
        .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data),
        .bus_resp_error(bus_resp_error)
    );

    memory_bridge #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .reset(reset),
        .command_valid(cmd_valid_b), .command_write(command_write), .misaligned(misaligned),
        .read_address(read_address), .write_address(write_address),
        .write_data(write_data), .write_mask(write_mask),
        .busy(busy_b), .done(done_b), .bus_error(err_b), .read_data(rdata_b),
        .bus_req_valid(valid_b), .bus_req_ready(bus_req_ready), .bus_req_write(write_b),
        .bus_req_address(addr_b), .bus_req_data(data_b), .bus_req_strobe(strobe_b),
        .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data),
        .bus_resp_error(bus_resp_error)
    );

    assign o_busy   = sel ? busy_b   : busy_a;
    assign o_done   = sel ? done_b   : done_a;
    assign o_err    = sel ? err_b    : err_a;
    assign o_valid  = sel ? valid_b  : valid_a;
    assign o_write  = sel ? write_b  : write_a;
    assign o_rdata  = sel ? rdata_b  : rdata_a;
    assign o_addr   = sel ? addr_b   : addr_a;
    assign o_data   = sel ? data_b   : data_a;
    assign o_strobe = sel ? strobe_b : strobe_a;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t sel=%0d)", tag, got, exp, $time, sel);
        end
    endtask

    // One command from the idle state, with the bus scheduled by the bench:
    // ready rises rdly cycles into REQ, response arrives rsdly cycles after acceptance.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] wmask, input int rdly, input int rsdly,
                           input bit err, input logic [31:0] rdata_in);
        int          limit;
        int          total;
        int          len;
        bit          timed_out;
        logic [31:0] exp_addr;
        logic [3:0]  exp_strobe;
        limit      = sel ? 4 : 255;
        total      = rdly + rsdly + 2;
        timed_out  = (total >= limit);
        len        = timed_out ? limit : total;
        exp_addr   = {addr[31:2], 2'b00};
        for (int i = 0; i < 4; i++) begin
            exp_strobe[i] = wr ? (((wmask >> (8 * i)) & 32'hFF) != 0) : 1'b1;
        end

        check("idle_busy", 32'(o_busy), 32'd0);
        command_valid  = 1'b1;
        command_write  = wr;
        misaligned     = 1'b0;
        read_address   = wr ? $urandom : addr;
        write_address  = wr ? addr : $urandom;
        write_data     = wdata;
        write_mask     = wmask;
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'b0;
        @(negedge clk);

        for (int c = 0; c < len; c++) begin
            check("busy", 32'(o_busy), 32'd1);
            check("done_early", 32'(o_done), 32'd0);
            check("err_no_done", 32'(o_err), 32'd0);
            check("req_valid", 32'(o_valid), 32'(c <= rdly));
            check("rdata_hold", o_rdata, rd_model[sel]);
            if (c <= rdly) begin
                check("req_addr", o_addr, exp_addr);
                check("req_strobe", 32'(o_strobe), 32'(exp_strobe));
                check("req_write", 32'(o_write), 32'(wr));
                check("req_data", o_data, wdata);
            end
            // Scrambled command inputs must be ignored while busy.
            command_valid = 1'($urandom);
            command_write = 1'($urandom);
            misaligned    = 1'($urandom);
            read_address  = $urandom;
            write_address = $urandom;
            write_data    = $urandom;
            write_mask    = $urandom;
            bus_req_ready = (c == rdly) ? 1'b1 : ((c < rdly) ? 1'b0 : 1'($urandom));
            if (c <= rdly) begin
                bus_resp_valid = 1'($urandom);
                bus_resp_data  = $urandom;
                bus_resp_error = 1'($urandom);
            end else if (c == rdly + 1 + rsdly) begin
                bus_resp_valid = 1'b1;
                bus_resp_data  = rdata_in;
                bus_resp_error = err;
            end else begin
                bus_resp_valid = 1'b0;
                bus_resp_data  = $urandom;
            end
            @(negedge clk);
        end

        if (!timed_out && !wr && !err) rd_model[sel] = rdata_in;
        check("done", 32'(o_done), 32'd1);
        check("done_err", 32'(o_err), 32'(timed_out || err));
        check("done_valid", 32'(o_valid), 32'd0);
        check("done_rdata", o_rdata, rd_model[sel]);
        command_valid  = 1'b0;
        misaligned     = 1'b0;
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'b0;
        @(negedge clk);
        check("after_done", 32'(o_done), 32'd0);
        check("after_err", 32'(o_err), 32'd0);
        check("after_busy", 32'(o_busy), 32'd0);
        check("after_rdata", o_rdata, rd_model[sel]);
    endtask

    task automatic refuse_misaligned(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            command_valid = 1'b1;
            misaligned    = 1'b1;
            command_write = 1'($urandom);
            read_address  = $urandom;
            write_address = $urandom;
            write_mask    = $urandom;
            @(negedge clk);
            check("mis_valid", 32'(o_valid), 32'd0);
            check("mis_busy", 32'(o_busy), 32'd0);
            check("mis_done", 32'(o_done), 32'd0);
        end
        command_valid = 1'b0;
        misaligned    = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b0;
        sel            = 1'b0;
        command_valid  = 1'b0;
        command_write  = 1'b0;
        misaligned     = 1'b0;
        read_address   = 32'd0;
        write_address  = 32'd0;
        write_data     = 32'd0;
        write_mask     = 32'd0;
        bus_req_ready  = 1'b0;
        bus_resp_valid = 1'b0;
        bus_resp_data  = 32'd0;
        bus_resp_error = 1'b0;
        rd_model[0]    = RESET_WORD;
        rd_model[1]    = RESET_WORD;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        check("rst_rdata", o_rdata, RESET_WORD);
        check("rst_addr", o_addr, 32'd0);
        check("rst_strobe", 32'(o_strobe), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Zero-wait read.
        run_txn(1'b0, 32'h0000_0104, 32'h5555_AAAA, 32'hFFFF_FFFF, 0, 0, 1'b0, 32'hDEAD_BEEF);
        check("t1_rdata", o_rdata, 32'hDEAD_BEEF);

        // Byte store with five cycles of backpressure.
        run_txn(1'b1, 32'h0000_0202, 32'h00AB_0000, 32'h00FF_0000, 5, 1, 1'b0, 32'hCAFE_F00D);
        check("t2_rdata", o_rdata, 32'hDEAD_BEEF);

        refuse_misaligned(4);

        // Timeout on the short-timeout instance, then stray responses while idle.
        sel = 1'b1;
        @(negedge clk);
        run_txn(1'b0, 32'h0000_0040, 32'h0, 32'h0, 10, 0, 1'b0, 32'h1111_1111);
        for (int c = 0; c < 3; c++) begin
            bus_resp_valid = 1'b1;
            bus_resp_error = 1'b0;
            bus_resp_data  = $urandom;
            @(negedge clk);
            check("stray_done", 32'(o_done), 32'd0);
            check("stray_busy", 32'(o_busy), 32'd0);
            check("stray_rdata", o_rdata, RESET_WORD);
        end
        bus_resp_valid = 1'b0;
        sel = 1'b0;
        @(negedge clk);

        // Error response leaves the held word alone.
        run_txn(1'b0, 32'h0000_0300, 32'h0, 32'h0, 1, 2, 1'b1, 32'h1234_5678);
        check("t5_rdata", o_rdata, 32'hDEAD_BEEF);

        // Randomized mix across both instances.
        for (int n = 0; n < 60; n++) begin
            sel = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) refuse_misaligned($urandom_range(1, 3));
            run_txn(1'($urandom), $urandom, $urandom, $urandom,
                    $urandom_range(0, 6), $urandom_range(0, 6),
                    ($urandom_range(0, 3) == 0), $urandom);
        end
        sel = 1'b0;
        @(negedge clk);

        // Asynchronous reset while waiting for a response.
        command_valid = 1'b1;
        command_write = 1'b0;
        read_address  = 32'h0000_0500;
        @(negedge clk);
        command_valid = 1'b0;
        bus_req_ready = 1'b1;
        @(negedge clk);
        bus_req_ready = 1'b0;
        check("pre_rst_busy", 32'(o_busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_busy", 32'(o_busy), 32'd0);
        check("arst_valid", 32'(o_valid), 32'd0);
        check("arst_done", 32'(o_done), 32'd0);
        check("arst_rdata", o_rdata, RESET_WORD);
        rd_model[0] = RESET_WORD;
        rd_model[1] = RESET_WORD;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_txn(1'b0, 32'h0000_0600, 32'h0, 32'h0, 0, 1, 1'b0, 32'hA5A5_5A5A);
        check("post_rst_rdata", o_rdata, 32'hA5A5_5A5A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/memory_bridge.md
Name: memory_bridge

Overview:
- Sits directly downstream of the data path's memory ports (read/write address, write data, 32-bit write mask) and upstream of the system memory bus.
- Turns one controller-issued memory command into a single valid/ready bus request, then waits for the bus response.
- Holds the returned load word stable for the data path and reports completion and bus errors to the controller.
- Lets the multi-cycle controller stall on variable-latency memory instead of assuming single-cycle RAM.

Parameters:
- TIMEOUT_CYCLES, 255, cycles spent in REQ+WAIT before a transaction is abandoned with bus_error; legal range 1..255, counter is 8 bits.
- RESET_READ_DATA, 32'h0000_0013, reset value of read_data (NOP encoding).

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- command_valid  input  1  controller requests a memory access this cycle.
- command_write  input  1  0 = read, 1 = write.
- misaligned  input  1  data path misaligned_exception; a command with this set is refused.
- read_address  input  32  data path read_memory_address.
- write_address  input  32  data path write_memory_address.
- write_data  input  32  data path write_memory_data.
- write_mask  input  32  data path write_memory_mask, bit-granular.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle completion pulse.
- bus_error  output  1  valid with done; response error or timeout.
- read_data  output  32  last successfully read word; feeds data path read_memory_data.
- bus_req_valid  output  1  request valid.
- bus_req_ready  input  1  bus accepts request.
- bus_req_write  output  1  latched command_write.
- bus_req_address  output  32  latched address, word-aligned (bits[1:0] forced to 0).
- bus_req_data  output  32  latched write_data.
- bus_req_strobe  output  4  strobe[i] = |write_mask[8i+7:8i] for writes, 4'b1111 for reads.
- bus_resp_valid  input  1  response present.
- bus_resp_data  input  32  read data.
- bus_resp_error  input  1  slave error flag, qualified by bus_resp_valid.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE and the timeout counter to 0.
  - bus_req_valid, done, bus_error and all latched request fields go to 0.
  - read_data goes to RESET_READ_DATA.
  - Reset mid-transaction abandons the transaction immediately; bus_req_valid drops in the same instant.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - command_valid=1 and misaligned=0: latch command_write, address, write_data and strobe, then go to REQ next cycle.
  - Address source is read_address when command_write=0, write_address when command_write=1.
  - command_valid=1 and misaligned=1: no latch, no bus activity, stay in IDLE, no done. The controller traps on misaligned.
- REQ:
  - bus_req_valid=1 with all request fields held constant until handshake.
  - bus_req_valid & bus_req_ready: go to WAIT.
  - A response arriving in the same cycle as acceptance is not sampled; the bus guarantees the response comes at least 1 cycle after acceptance.
- WAIT:
  - bus_req_valid=0.
  - On bus_resp_valid: go to DONE.
  - If read and bus_resp_error=0, load read_data from bus_resp_data.
  - Register bus_error = bus_resp_error.
  - Write responses never change read_data.
- DONE: done=1 for exactly one cycle, bus_error valid, then go to IDLE.
- Timeout:
  - The counter clears on IDLE->REQ and increments each cycle in REQ or WAIT.
  - When the counter reaches TIMEOUT_CYCLES without progress to DONE, go to DONE with bus_error=1.
  - bus_req_valid drops on the next cycle; read_data is unchanged.
  - Timeout has priority over a handshake or response in the same cycle.
- Late or stray bus_resp_valid in IDLE or REQ is ignored.
- command_valid while busy=1 is ignored; the controller must wait for done.
- Minimum latency: command in cycle N, REQ in N+1 (ready=1), WAIT in N+2 (resp_valid=1), done in N+3.
- read_data is only ever updated by a successful read response; it holds across writes, errors and timeouts.
- bus_error=0 whenever done=0.

Test Plan:
1. Read, zero wait:
   - Stimulus: command_valid, read, read_address=0x0000_0104; ready=1 in REQ; resp_data=0xDEAD_BEEF in the first WAIT cycle.
   - Required: bus_req_address=0x104, strobe=4'b1111, done exactly 3 cycles after the command, read_data=0xDEAD_BEEF, bus_error=0.
2. Byte store with backpressure:
   - Stimulus: write_address=0x202, write_mask=0x00FF_0000, write_data=0x00AB_0000; bus_req_ready held low 5 cycles.
   - Required: request fields stable throughout, address=0x200, strobe=4'b0100, done after the response, read_data unchanged.
3. Misaligned refusal:
   - Stimulus: command_valid=1 with misaligned=1.
   - Required: bus_req_valid never asserted, busy stays 0, no done.
4. Timeout:
   - Stimulus: TIMEOUT_CYCLES=4; bus_req_ready held 0.
   - Required: done with bus_error=1 four cycles after entering REQ, read_data unchanged. A later stray bus_resp_valid in IDLE has no effect.
5. Error response:
   - Stimulus: read whose response has bus_resp_error=1 and data 0x1234_5678.
   - Required: done with bus_error=1, read_data keeps its previous value.
6. Async reset mid-WAIT:
   - Stimulus: assert reset low between clock edges while in WAIT.
   - Required: busy=0, bus_req_valid=0 and read_data=0x0000_0013 immediately. After release, a new read completes normally.
